rv32i_decode_stage: RTL and testbench
=====================================

Name: rv32i_decode_stage

Overview:
- IF/ID pipeline stage. Accepts 32-bit instruction + PC from fetch over a valid/ready handshake.
- Decodes opcode/funct3/funct7 and generates the immediate.
- Presents registered control bundle to execute over a second valid/ready handshake.
- Contains a 2-entry skid buffer so o_if_ready is a register output; sustains 1 instr/cycle.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- RESET_PC, 32'h0000_0000, value driven on o_pc during reset

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_if_valid  in  1  fetch has instruction
- o_if_ready  out  1  stage can accept (registered)
- i_if_instr  in  32  instruction word
- i_if_pc  in  32  PC of instruction
- i_flush  in  1  kill all held/incoming instructions (branch mispredict)
- o_ex_valid  out  1  decoded bundle valid
- i_ex_ready  in  1  execute accepts bundle
- o_pc  out  32  PC of bundle
- o_rs1, o_rs2, o_rd  out  5 each  register addresses (0 when unused)
- o_imm  out  32  sign-extended immediate
- o_alu_op  out  4  alu_op_t
- o_alu_src_imm  out  1  ALU operand B = imm
- o_alu_src_pc  out  1  ALU operand A = PC (AUIPC, JAL)
- o_reg_write  out  1  writes rd (forced 0 when rd==0)
- o_mem_read, o_mem_write  out  1 each  load/store
- o_funct3  out  3  passthrough for LSU size / branch compare
- o_branch, o_jump  out  1 each  BRANCH / JAL-JALR
- o_illegal  out  1  undecodable instruction

Behaviour:
- Reset: o_ex_valid=0, o_if_ready=1, o_pc=RESET_PC, every other output 0, FSM=EMPTY.
- Latency: 1 cycle from accepted input to o_ex_valid.
- Transfer rules: input transfer = i_if_valid & o_if_ready; output transfer = o_ex_valid & i_ex_ready. Bundle stays stable while o_ex_valid & !i_ex_ready.
- FSM states:
  - EMPTY: out reg empty. In xfer -> FULL.
  - FULL: out valid. In xfer & !out xfer -> SKID (capture into skid reg). Out xfer & !in -> EMPTY. Both -> FULL (new bundle loaded).
  - SKID: both regs held; o_if_ready=0. Out xfer -> FULL (skid moves to out).
- o_if_ready = (state != SKID), registered.
- Flush: i_flush wins over everything. Next cycle FSM=EMPTY, o_ex_valid=0, o_if_ready=1. An input presented in the flush cycle is dropped. Data registers may retain stale values.
- Immediate by opcode:
  - I-type (OP_IMM, LOAD, JALR): instr[31:20]
  - S-type: {instr[31:25], instr[11:7]}
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U-type: {instr[31:12], 12'b0}
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All sign-extended from instr[31].
- ALU op:
  - OP: funct3 selects the op; funct7[5] selects SUB/SRA.
  - OP_IMM: funct7[5] honoured only for SRAI.
  - LOAD/STORE/AUIPC/JAL/JALR: ADD. LUI: PASS_B.
  - BRANCH: SUB (compare done in execute using o_funct3).
- Illegal: unknown opcode; or OP with funct7 not in {0x00, 0x20}; or funct7=0x20 with funct3 not in {ADD, SRL}. Illegal forces reg_write/mem_read/mem_write/branch/jump to 0.

Optional Feature:
- RV32I_DECODE_ILLEGAL_EN
  - Defined: illegal detection as above.
  - Undefined: o_illegal tied 0; unknown opcodes decode as NOP (all enables 0) with no check logic.

Decomposition:
- Shared RV32I definitions package gains:
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - imm_fmt_t enum: I, S, B, U, J.
  - FUNCT7_BASE=7'h00, FUNCT7_ALT=7'h20.
  - decode_bundle_t packed struct used for both out and skid registers.
- Sub-module rv32i_imm_gen: combinational (instr, imm_fmt) -> imm.

Test Plan:
- ADDI x1,x2,5 (0x00510093) -> next cycle o_ex_valid=1, rd=1, rs1=2, imm=5, alu=ADD, alu_src_imm=1, reg_write=1.
- SUB x3,x1,x2 (0x402081B3) -> alu=SUB, rs1=1, rs2=2, rd=3, alu_src_imm=0.
- BEQ x0,x0,-4 (0xFE000EE3), PC=0x100 -> imm=0xFFFFFFFC, branch=1, reg_write=0, o_pc=0x100.
- Back-to-back valid, i_ex_ready low 3 cycles -> o_if_ready drops 1 cycle after first stall. No instruction lost or duplicated; order preserved on release.
- i_flush in SKID state with i_if_valid=1 -> next cycle o_ex_valid=0, o_if_ready=1; none of the 3 instructions ever appear.
- 0x0000007F with macro defined -> o_illegal=1, all enables 0; without macro -> o_illegal=0, all enables 0.

Source files
------------

// File: rtl/rv32i_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_decode_stage_pkg
// Shared RV32I definitions for the decode stage: opcode/funct constants, ALU
// op and immediate-format enums, the decoded bundle carried by the output and
// skid registers, the stage FSM encoding and a funct3 -> ALU op helper.
// -----------------------------------------------------------------------------
package rv32i_decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SRL = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_t     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic        illegal;
  } decode_bundle_t;

  // alt selects SUB (funct3=ADD) or SRA (funct3=SRL); ignored otherwise.
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// -----------------------------------------------------------------------------
// rv32i_imm_gen
// Combinational immediate generator. Every format is sign-extended from
// instr[31].
// Ports:
//   i_instr  instruction word
//   i_fmt    immediate format (I/S/B/U/J)
//   o_imm    sign-extended immediate
// -----------------------------------------------------------------------------
module rv32i_imm_gen
  import rv32i_decode_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  input  imm_fmt_t    i_fmt,
  output logic [31:0] o_imm
);

  always_comb begin
    case (i_fmt)
      IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:   o_imm = {i_instr[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
    endcase
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// -----------------------------------------------------------------------------
// rv32i_decode_stage
// IF/ID stage: decodes an RV32I instruction and hands a registered control
// bundle to execute. An output register plus one skid register let
// o_if_ready come straight from a flop while still sustaining 1 instr/cycle.
//
// Optional feature macro: RV32I_DECODE_ILLEGAL_EN
//   defined   - unknown opcodes and bad OP funct7/funct3 combos raise
//               o_illegal and suppress all side-effect enables
//   undefined - o_illegal stays 0; unknown opcodes decode as a NOP
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_if_valid/o_if_ready        fetch handshake (ready is registered)
//   i_if_instr, i_if_pc          instruction and its PC
//   i_flush                      drop everything held and incoming
//   o_ex_valid/i_ex_ready        execute handshake
//   o_pc .. o_illegal            decoded bundle fields
// -----------------------------------------------------------------------------
module rv32i_decode_stage
  import rv32i_decode_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  input  logic [XLEN-1:0] i_if_instr,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic            i_flush,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_imm,
  output logic [3:0]      o_alu_op,
  output logic            o_alu_src_imm,
  output logic            o_alu_src_pc,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic [2:0]      o_funct3,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal
);

  logic [6:0]     w_opc;
  logic [6:0]     w_f7;
  logic [2:0]     w_f3;
  imm_fmt_t       w_fmt;
  logic           w_use_imm;
  logic [31:0]    w_imm;
  decode_bundle_t w_dec;
  logic           w_in_xfer;
  logic           w_out_xfer;

  state_t         r_state;
  logic           r_if_ready;
  logic           r_ex_valid;
  decode_bundle_t r_out;
  decode_bundle_t r_skid;

  assign w_opc = i_if_instr[6:0];
  assign w_f3  = i_if_instr[14:12];
  assign w_f7  = i_if_instr[31:25];

  rv32i_imm_gen u_imm_gen (
    .i_instr (i_if_instr),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  // Unused register fields stay 0 so hazard logic downstream never sees
  // a false dependency.
  always_comb begin
    w_dec        = '0;
    w_fmt        = IMM_I;
    w_use_imm    = 1'b0;
    w_dec.pc     = i_if_pc;
    w_dec.funct3 = w_f3;
    case (w_opc)
      OPC_OP: begin
        w_dec.rs1       = i_if_instr[19:15];
        w_dec.rs2       = i_if_instr[24:20];
        w_dec.rd        = i_if_instr[11:7];
        w_dec.alu_op    = f3_to_alu(w_f3, w_f7[5]);
        w_dec.reg_write = 1'b1;
`ifdef RV32I_DECODE_ILLEGAL_EN
        if (!(w_f7 == FUNCT7_BASE || w_f7 == FUNCT7_ALT) ||
            (w_f7 == FUNCT7_ALT && w_f3 != F3_ADD && w_f3 != F3_SRL))
          w_dec.illegal = 1'b1;
`endif
      end
      OPC_OP_IMM: begin
        w_dec.rs1         = i_if_instr[19:15];
        w_dec.rd          = i_if_instr[11:7];
        // Only SRAI uses funct7; for ADDI the same bit is immediate data.
        w_dec.alu_op      = f3_to_alu(w_f3, (w_f3 == F3_SRL) && w_f7[5]);
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_use_imm         = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.rs1         = i_if_instr[19:15];
        w_dec.rd          = i_if_instr[11:7];
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.mem_read    = 1'b1;
        w_use_imm         = 1'b1;
      end
      OPC_STORE: begin
        w_dec.rs1         = i_if_instr[19:15];
        w_dec.rs2         = i_if_instr[24:20];
        w_dec.alu_src_imm = 1'b1;
        w_dec.mem_write   = 1'b1;
        w_fmt             = IMM_S;
        w_use_imm         = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.rs1    = i_if_instr[19:15];
        w_dec.rs2    = i_if_instr[24:20];
        w_dec.alu_op = ALU_SUB;
        w_dec.branch = 1'b1;
        w_fmt        = IMM_B;
        w_use_imm    = 1'b1;
      end
      OPC_LUI: begin
        w_dec.rd          = i_if_instr[11:7];
        w_dec.alu_op      = ALU_PASS_B;
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_fmt             = IMM_U;
        w_use_imm         = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.rd          = i_if_instr[11:7];
        w_dec.alu_src_imm = 1'b1;
        w_dec.alu_src_pc  = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_fmt             = IMM_U;
        w_use_imm         = 1'b1;
      end
      OPC_JAL: begin
        w_dec.rd          = i_if_instr[11:7];
        w_dec.alu_src_imm = 1'b1;
        w_dec.alu_src_pc  = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.jump        = 1'b1;
        w_fmt             = IMM_J;
        w_use_imm         = 1'b1;
      end
      OPC_JALR: begin
        w_dec.rs1         = i_if_instr[19:15];
        w_dec.rd          = i_if_instr[11:7];
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
        w_dec.jump        = 1'b1;
        w_use_imm         = 1'b1;
      end
      default: begin
`ifdef RV32I_DECODE_ILLEGAL_EN
        w_dec.illegal = 1'b1;
`endif
      end
    endcase
    w_dec.imm = w_use_imm ? w_imm : '0;
    if (w_dec.rd == 5'd0) w_dec.reg_write = 1'b0;
`ifdef RV32I_DECODE_ILLEGAL_EN
    if (w_dec.illegal) begin
      w_dec.reg_write = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.jump      = 1'b0;
    end
`endif
  end

  assign w_in_xfer  = i_if_valid & r_if_ready;
  assign w_out_xfer = r_ex_valid & i_ex_ready;

  // Handshake FSM; ready/valid are registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_if_ready <= 1'b1;
      r_ex_valid <= 1'b0;
      r_out      <= '0;
      r_out.pc   <= RESET_PC;
      r_skid     <= '0;
    end else if (i_flush) begin
      r_state    <= ST_EMPTY;
      r_if_ready <= 1'b1;
      r_ex_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_out      <= w_dec;
            r_ex_valid <= 1'b1;
            r_state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_in_xfer && !w_out_xfer) begin
            r_skid     <= w_dec;
            r_if_ready <= 1'b0;
            r_state    <= ST_SKID;
          end else if (w_out_xfer && !w_in_xfer) begin
            r_ex_valid <= 1'b0;
            r_state    <= ST_EMPTY;
          end else if (w_in_xfer && w_out_xfer) begin
            r_out <= w_dec;
          end
        end
        ST_SKID: begin
          if (w_out_xfer) begin
            r_out      <= r_skid;
            r_if_ready <= 1'b1;
            r_state    <= ST_FULL;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_if_ready <= 1'b1;
          r_ex_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_if_ready    = r_if_ready;
  assign o_ex_valid    = r_ex_valid;
  assign o_pc          = r_out.pc;
  assign o_rs1         = r_out.rs1;
  assign o_rs2         = r_out.rs2;
  assign o_rd          = r_out.rd;
  assign o_imm         = r_out.imm;
  assign o_alu_op      = r_out.alu_op;
  assign o_alu_src_imm = r_out.alu_src_imm;
  assign o_alu_src_pc  = r_out.alu_src_pc;
  assign o_reg_write   = r_out.reg_write;
  assign o_mem_read    = r_out.mem_read;
  assign o_mem_write   = r_out.mem_write;
  assign o_funct3      = r_out.funct3;
  assign o_branch      = r_out.branch;
  assign o_jump        = r_out.jump;
  assign o_illegal     = r_out.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
module tb_rv32i_decode_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SRA = 4'd7, A_PASSB = 4'd10;
`ifdef RV32I_DECODE_ILLEGAL_EN
  localparam logic IL = 1'b1;
`else
  localparam logic IL = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [4:0]  ctl;   // {src_imm, src_pc, reg_write, mem_read, mem_write}
    logic [2:0]  f3;
    logic [2:0]  bji;   // {branch, jump, illegal}
  } bun_t;

  logic        clk = 0, rst;
  logic        if_valid, if_ready, flush, ex_valid, ex_ready;
  logic [31:0] if_instr, if_pc, pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic        src_imm, src_pc, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [2:0]  funct3;
  bun_t        cur;
  bun_t        exp_q[$];
  bun_t        got_q[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  rv32i_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_valid(if_valid), .o_if_ready(if_ready),
    .i_if_instr(if_instr), .i_if_pc(if_pc), .i_flush(flush),
    .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
    .o_pc(pc), .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd), .o_imm(imm),
    .o_alu_op(alu_op), .o_alu_src_imm(src_imm), .o_alu_src_pc(src_pc),
    .o_reg_write(reg_write), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_funct3(funct3), .o_branch(branch), .o_jump(jump), .o_illegal(illegal)
  );

  assign cur = {pc, rs1, rs2, rd, imm, alu_op,
                {src_imm, src_pc, reg_write, mem_read, mem_write},
                funct3, {branch, jump, illegal}};

  function automatic bun_t mk(input logic [31:0] p, input logic [4:0] s1, s2, d,
                              input logic [31:0] im, input logic [3:0] a,
                              input logic [4:0] c, input logic [2:0] f, input logic [2:0] b);
    return {p, s1, s2, d, im, a, c, f, b};
  endfunction

  // One clock: inputs applied now, handshakes observed mid-cycle, then the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input bun_t e, input logic er, input logic fl, output logic acc);
    if_valid = v; if_instr = ins; if_pc = p; ex_ready = er; flush = fl;
    @(negedge clk);
    acc = v & if_ready & !fl;
    if (acc) exp_q.push_back(e);
    if (ex_valid && er && !fl) got_q.push_back(cur);
    @(posedge clk); #1;
    if_valid = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; ex_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b exp 0", ex_valid); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b exp 1", if_ready); end
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, RST_PC); end
    checks++;
    if ({rs1, rs2, rd, imm, alu_op, src_imm, src_pc, reg_write, mem_read, mem_write,
         funct3, branch, jump, illegal} !== '0) begin
      errors++; $display("FAIL reset_others: got %h exp 0", cur);
    end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_decode();
    logic [31:0] ins[12];
    bun_t        e[12];
    logic        acc;
    int          i, cyc;
    ins[0]  = 32'h00510093; e[0]  = mk(32'h1000, 2, 0, 1, 32'd5, A_ADD, 5'b10100, 0, 3'b000);
    ins[1]  = 32'h402081B3; e[1]  = mk(32'h1004, 1, 2, 3, 32'd0, A_SUB, 5'b00100, 0, 3'b000);
    ins[2]  = 32'hFE000EE3; e[2]  = mk(32'h0100, 0, 0, 0, 32'hFFFFFFFC, A_SUB, 5'b00000, 0, 3'b100);
    ins[3]  = 32'h123452B7; e[3]  = mk(32'h100C, 0, 0, 5, 32'h12345000, A_PASSB, 5'b10100, 5, 3'b000);
    ins[4]  = 32'h0020A423; e[4]  = mk(32'h1010, 1, 2, 0, 32'd8, A_ADD, 5'b10001, 2, 3'b000);
    ins[5]  = 32'hFF9FF0EF; e[5]  = mk(32'h1014, 0, 0, 1, 32'hFFFFFFF8, A_ADD, 5'b11100, 7, 3'b010);
    ins[6]  = 32'h00208033; e[6]  = mk(32'h1018, 1, 2, 0, 32'd0, A_ADD, 5'b00000, 0, 3'b000);
    ins[7]  = 32'h4032D213; e[7]  = mk(32'h101C, 5, 0, 4, 32'h403, A_SRA, 5'b10100, 5, 3'b000);
    ins[8]  = 32'hFFF3A303; e[8]  = mk(32'h1020, 7, 0, 6, 32'hFFFFFFFF, A_ADD, 5'b10110, 2, 3'b000);
    ins[9]  = 32'h80000417; e[9]  = mk(32'h1024, 0, 0, 8, 32'h80000000, A_ADD, 5'b11100, 0, 3'b000);
    ins[10] = 32'h0020A4B3; e[10] = mk(32'h1028, 1, 2, 9, 32'd0, A_SLT, 5'b00100, 2, 3'b000);
    ins[11] = 32'h000280E7; e[11] = mk(32'h102C, 5, 0, 1, 32'd0, A_ADD, 5'b10100, 0, 3'b010);
    // First instruction with execute stalled: valid must appear one cycle later.
    step(1, ins[0], e[0].pc, e[0], 0, 0, acc);
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b exp 1", ex_valid); end
    i = acc ? 1 : 0; cyc = 0;
    while ((i < 12 || ex_valid) && cyc < 60) begin
      if (i < 12) step(1, ins[i], e[i].pc, e[i], 1, 0, acc);
      else        step(0, 0, 0, '0, 1, 0, acc);
      if (acc) i++;
      cyc++;
    end
    checks++; if (got_q.size() != exp_q.size() || cyc >= 60) begin
      errors++; $display("FAIL decode_count: got %0d exp %0d (cycles %0d)", got_q.size(), exp_q.size(), cyc);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      bun_t g, x; g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin errors++; $display("FAIL decode_pc%h: got %h exp %h", x.pc, g, x); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic acc, er;
    int   idx = 0, occ = 0, k = 0, outx;
    while ((idx < 6 || occ > 0) && k < 40) begin
      er = !(k inside {1, 2, 3});
      outx = (occ > 0 && er) ? 1 : 0;
      if (idx < 6) step(1, 32'h00000093 | (idx << 20), 32'h2000 + idx*4,
                        mk(32'h2000 + idx*4, 0, 0, 1, idx, A_ADD, 5'b10100, 0, 3'b000), er, 0, acc);
      else         step(0, 0, 0, '0, er, 0, acc);
      if (acc) idx++;
      occ = occ + (acc ? 1 : 0) - outx;
      checks++; if (if_ready !== (occ < 2)) begin
        errors++; $display("FAIL b2b_ready_cyc%0d: got %b exp %b", k, if_ready, occ < 2);
      end
      checks++; if (ex_valid !== (occ > 0)) begin
        errors++; $display("FAIL b2b_valid_cyc%0d: got %b exp %b", k, ex_valid, occ > 0);
      end
      k++;
    end
    checks++; if (got_q.size() != 6 || exp_q.size() != 6) begin
      errors++; $display("FAIL b2b_count: got %0d exp 6 (pushed %0d)", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      bun_t g, x; g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin errors++; $display("FAIL b2b_order: got %h exp %h", g, x); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush();
    logic acc;
    for (int j = 0; j < 3; j++)
      step(1, 32'h06400093 + (j << 20), 32'h3000 + j*4,
           mk(32'h3000 + j*4, 0, 0, 1, 100 + j, A_ADD, 5'b10100, 0, 3'b000), 0, j == 2, acc);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", ex_valid); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", if_ready); end
    exp_q.delete();
    repeat (4) step(0, 0, 0, '0, 1, 0, acc);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL flush_leak: got %0d exp 0", got_q.size()); end
    got_q.delete();
    step(1, 32'h04D00093, 32'h3100, mk(32'h3100, 0, 0, 1, 77, A_ADD, 5'b10100, 0, 3'b000), 1, 0, acc);
    step(0, 0, 0, '0, 1, 0, acc);
    checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL flush_after_count: got %0d exp 1", got_q.size());
    end else begin
      bun_t g, x; g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin errors++; $display("FAIL flush_after: got %h exp %h", g, x); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal();
    logic [31:0] ins[3];
    bun_t        e[3];
    logic        acc;
    ins[0] = 32'h0000007F; e[0] = mk(32'h4000, 0, 0, 0, 0, A_ADD, 5'b00000, 0, {2'b00, IL});
    ins[1] = 32'h40209033; e[1] = mk(32'h4004, 1, 2, 0, 0, A_SLL, 5'b00000, 1, {2'b00, IL});
    ins[2] = 32'h022081B3; e[2] = mk(32'h4008, 1, 2, 3, 0, A_ADD, IL ? 5'b00000 : 5'b00100, 0, {2'b00, IL});
    for (int j = 0; j < 3; j++) step(1, ins[j], e[j].pc, e[j], 1, 0, acc);
    step(0, 0, 0, '0, 1, 0, acc);
    checks++; if (got_q.size() != 3 || exp_q.size() != 3) begin
      errors++; $display("FAIL illegal_count: got %0d exp 3 (pushed %0d)", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      bun_t g, x; g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin errors++; $display("FAIL illegal_pc%h: got %h exp %h", x.pc, g, x); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
